// File: rtl/lsu_mem_if.sv
// RV32I load/store unit: drives a valid/ready data bus and returns extended load data.
// Latency: store 2 stall cycles, load 3 stall cycles (ready=1, response in the next cycle).
// Backpressure: request fields are held until accepted; an optional cycle budget aborts with fault.
module lsu_mem_if #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        fault,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rsp_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

   typedef struct packed {
      logic [2:0] func3;
      logic [1:0] off;
   } req_meta_t;

   // Counter can reach TIMEOUT when an accept lands on the last allowed REQ cycle.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   state_t          state, state_nxt;
   req_meta_t       meta;
   logic [CW-1:0]   to_cnt;
   logic            acc, bad, is_h, is_w;
   logic            start, capture, abort, timed_out;
   logic [31:0]     lane, ext, rep_wdata;
   logic [3:0]      strb;

   assign acc  = mem_read | mem_write;
   assign is_h = (func3[1:0] == 2'b01);
   assign is_w = (func3[1:0] == 2'b10);
   assign bad  = (mem_read & mem_write)
               | (func3[1:0] == 2'b11)
               | (func3[2] & func3[1])
               | (mem_write & func3[2])
               | (is_h & addr[0])
               | (is_w & (addr[1:0] != 2'b00));

   assign stall     = acc & ~bad & (state != DONE);
   assign timed_out = (TIMEOUT != 0) && (to_cnt >= TO_LAST);

   always_comb begin
      rep_wdata = wdata;
      strb      = 4'b1111;
      case (func3[1:0])
         2'b00: begin
            rep_wdata = {4{wdata[7:0]}};
            strb      = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            rep_wdata = {2{wdata[15:0]}};
            strb      = 4'b0011 << addr[1:0];
         end
         default: ;
      endcase
      if (!mem_write) strb = 4'b0000;
   end

   assign lane = bus_rsp_rdata >> {meta.off, 3'b000};

   always_comb begin
      ext = lane;
      case (meta.func3)
         3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ext = {24'b0, lane[7:0]};
         3'b101:  ext = {16'b0, lane[15:0]};
         default: ext = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (acc && !bad) begin
               start     = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (bus_req_valid && bus_req_ready) begin
               state_nxt = bus_we ? DONE : WAIT_RSP;
            end else if (timed_out) begin
               abort     = 1'b1;
               state_nxt = DONE;
            end
         end
         WAIT_RSP: begin
            if (bus_rsp_valid) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end else if (timed_out) begin
               abort     = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req_valid <= 1'b0;
         bus_we        <= 1'b0;
         bus_addr      <= '0;
         bus_wdata     <= '0;
         bus_wstrb     <= '0;
         load_data     <= '0;
         fault         <= 1'b0;
         meta          <= '0;
         to_cnt        <= '0;
      end else begin
         fault     <= ((state == IDLE) & acc & bad) | abort;
         load_data <= capture ? ext : 32'h0;
         if (start) begin
            bus_req_valid <= 1'b1;
            bus_we        <= mem_write;
            bus_addr      <= {addr[31:2], 2'b00};
            bus_wdata     <= rep_wdata;
            bus_wstrb     <= strb;
            meta          <= '{func3: func3, off: addr[1:0]};
            to_cnt        <= '0;
         end else begin
            if (state == REQ && state_nxt != REQ) bus_req_valid <= 1'b0;
            if ((state == REQ || state == WAIT_RSP) && TIMEOUT != 0) to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed vector bench for lsu_mem_if plus stall, timeout and reset-abandon sequences.
module tb_lsu_mem_if;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, mem_read, mem_write;
   logic [2:0]  func3;
   logic [31:0] addr, wdata;
   logic        bus_req_ready, bus_rsp_valid;
   logic [31:0] bus_rsp_rdata;
   logic        stall, fault, bus_req_valid, bus_we;
   logic [31:0] load_data, bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;

   logic        to_req_ready, to_rsp_valid;
   logic [31:0] to_rsp_rdata;
   logic        to_stall, to_fault, to_req_valid, to_we;
   logic [31:0] to_load_data, to_addr, to_wdata;
   logic [3:0]  to_wstrb;

   lsu_mem_if dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
      .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data), .fault(fault),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
   );

   lsu_mem_if #(.TIMEOUT(4)) dut_to (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
      .addr(addr), .wdata(wdata), .stall(to_stall), .load_data(to_load_data), .fault(to_fault),
      .bus_req_valid(to_req_valid), .bus_req_ready(to_req_ready), .bus_we(to_we),
      .bus_addr(to_addr), .bus_wdata(to_wdata), .bus_wstrb(to_wstrb),
      .bus_rsp_valid(to_rsp_valid), .bus_rsp_rdata(to_rsp_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rdata;
      logic        bad;
      logic [3:0]  strb;
      logic [31:0] bwd;
      logic [31:0] ld;
      int          stalls;
   } vec_t;

   vec_t vecs[15];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000; addr = '0; wdata = '0;
      bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int stalls = 0;
      bit done = 0, saw_req = 0, rsp_pend = 0;
      mem_read = v.rd; mem_write = v.wr; func3 = v.f3; addr = v.a; wdata = v.wd;
      bus_req_ready = 1'b1; bus_rsp_valid = 1'b0; bus_rsp_rdata = v.rdata;
      if (v.bad) begin
         @(negedge clk);
         check($sformatf("v%0d bad_stall", idx), {31'b0, stall}, 32'd0);
         check($sformatf("v%0d bad_no_req0", idx), {31'b0, bus_req_valid}, 32'd0);
         step();
         idle_inputs();
         @(negedge clk);
         check($sformatf("v%0d fault", idx), {31'b0, fault}, 32'd1);
         check($sformatf("v%0d bad_no_req1", idx), {31'b0, bus_req_valid}, 32'd0);
         step();
         @(negedge clk);
         check($sformatf("v%0d fault_pulse_end", idx), {31'b0, fault}, 32'd0);
         step();
      end else begin
         for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
               done = 1;
            end else begin
               stalls++;
               if (bus_req_valid && !saw_req) begin
                  saw_req = 1;
                  check($sformatf("v%0d we", idx), {31'b0, bus_we}, {31'b0, v.wr});
                  check($sformatf("v%0d addr", idx), bus_addr, v.a & 32'hFFFF_FFFC);
                  check($sformatf("v%0d wstrb", idx), {28'b0, bus_wstrb}, {28'b0, v.strb});
                  if (v.wr) check($sformatf("v%0d wdata", idx), bus_wdata, v.bwd);
               end
               if (bus_req_valid && bus_req_ready && v.rd) rsp_pend = 1;
               step();
               bus_rsp_valid = rsp_pend;
               rsp_pend = 0;
            end
         end
         check($sformatf("v%0d done_reached", idx), {31'b0, done}, 32'd1);
         check($sformatf("v%0d saw_req", idx), {31'b0, saw_req}, 32'd1);
         check($sformatf("v%0d stall_cycles", idx), stalls, v.stalls);
         check($sformatf("v%0d done_fault", idx), {31'b0, fault}, 32'd0);
         check($sformatf("v%0d done_valid", idx), {31'b0, bus_req_valid}, 32'd0);
         check($sformatf("v%0d load_data", idx), load_data, v.ld);
         step();
         idle_inputs();
         @(negedge clk);
         check($sformatf("v%0d idle_load_data", idx), load_data, 32'd0);
         step();
      end
   endtask

   initial begin
      int stalls;
      bit done;
      rst = 1'b1;
      bus_req_ready = 1'b0;
      to_req_ready = 1'b0; to_rsp_valid = 1'b0; to_rsp_rdata = '0;
      idle_inputs();

      //            rd    wr    f3      addr          wdata         rdata         bad   strb   bus_wdata     load_data     stalls
      vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0,        2};
      vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1'b0, 4'h8, 32'hA5A5_A5A5, 32'h0,        2};
      vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0,        1'b0, 4'hC, 32'hBEEF_BEEF, 32'h0,        2};
      vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1122_3344, 32'h0,        1'b0, 4'h2, 32'h4444_4444, 32'h0,        2};
      vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h0080_7F00, 1'b0, 4'h0, 32'h0,        32'hFFFF_FF80, 3};
      vecs[5]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h0080_7F00, 1'b0, 4'h0, 32'h0,        32'h0000_0080, 3};
      vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h0080_7F00, 1'b0, 4'h0, 32'h0,        32'h0000_0080, 3};
      vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7F00, 1'b0, 4'h0, 32'h0,        32'hFFFF_8001, 3};
      vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'h1234_5678, 1'b0, 4'h0, 32'h0,        32'h1234_5678, 3};
      vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0080_7F00, 1'b0, 4'h0, 32'h0,        32'h0000_007F, 3};
      vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        0};
      vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        0};
      vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        0};
      vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        0};
      vecs[14] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        0};

      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", {31'b0, bus_req_valid}, 32'd0);
      check("rst_we", {31'b0, bus_we}, 32'd0);
      check("rst_addr", bus_addr, 32'd0);
      check("rst_wdata", bus_wdata, 32'd0);
      check("rst_wstrb", {28'b0, bus_wstrb}, 32'd0);
      check("rst_load_data", load_data, 32'd0);
      check("rst_fault", {31'b0, fault}, 32'd0);
      step();

      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

      // Load held off by ready=0 for 5 cycles; inputs and a stray response change meanwhile.
      mem_read = 1'b1; func3 = 3'b010; addr = 32'h0000_0200; bus_req_ready = 1'b0;
      @(negedge clk);
      step();
      addr = 32'h0000_0300; func3 = 3'b000;
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hBAD0_BAD0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("hold%0d valid", k), {31'b0, bus_req_valid}, 32'd1);
         check($sformatf("hold%0d addr", k), bus_addr, 32'h0000_0200);
         check($sformatf("hold%0d we_strb", k), {27'b0, bus_we, bus_wstrb}, 32'd0);
         check($sformatf("hold%0d stall", k), {31'b0, stall}, 32'd1);
         step();
         bus_rsp_valid = 1'b0;
      end
      bus_req_ready = 1'b1;
      @(negedge clk);
      step();
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      check("hold wait_stall", {31'b0, stall}, 32'd1);
      step();
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      check("hold done_stall", {31'b0, stall}, 32'd0);
      check("hold load_data", load_data, 32'hCAFE_F00D);
      step();
      idle_inputs();

      // Timeout after 4 cycles in REQ on the TIMEOUT=4 instance.
      pulse_reset();
      mem_read = 1'b1; func3 = 3'b010; addr = 32'h0000_0040;
      stalls = 0; done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (!to_stall) done = 1;
         else begin
            stalls++;
            step();
         end
      end
      check("to done_reached", {31'b0, done}, 32'd1);
      check("to stall_cycles", stalls, 32'd5);
      check("to fault", {31'b0, to_fault}, 32'd1);
      check("to load_data", to_load_data, 32'd0);
      check("to valid_dropped", {31'b0, to_req_valid}, 32'd0);
      step();
      idle_inputs();
      @(negedge clk);
      check("to fault_pulse_end", {31'b0, to_fault}, 32'd0);
      step();

      // Reset while waiting for a read response; the late response must be ignored.
      pulse_reset();
      mem_read = 1'b1; func3 = 3'b010; addr = 32'h0000_0010; bus_req_ready = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      check("rw req_valid", {31'b0, bus_req_valid}, 32'd1);
      step();
      @(negedge clk);
      check("rw in_wait", {30'b0, bus_req_valid, stall}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0; mem_read = 1'b0;
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("rw valid", {31'b0, bus_req_valid}, 32'd0);
      check("rw fields", bus_addr | bus_wdata | {27'b0, bus_we, bus_wstrb}, 32'd0);
      check("rw load_data", load_data, 32'd0);
      check("rw fault_stall", {30'b0, fault, stall}, 32'd0);
      step();
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      check("rw ignored_load", load_data, 32'd0);
      check("rw ignored_fault", {31'b0, fault}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
